// File: rtl/route_pkg.sv
// rtl/route_pkg.sv - shared state type, grant constants and grant decode helpers
package route_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_ROUTE,
        ST_SETTLE,
        ST_PROCEED,
        ST_OCCUPIED,
        ST_CLEARING,
        ST_DONE,
        ST_HOLDOFF,
        ST_FAULT
    } route_state_t;

    localparam logic [2:0] GRANT_NONE = 3'd0;
    localparam int NUM_TRAINS = 4;

    function automatic logic grant_valid(input logic [2:0] grant);
        return (grant != GRANT_NONE) && (int'(grant) <= NUM_TRAINS);
    endfunction

    function automatic logic [1:0] grant_to_route(input logic [2:0] grant);
        return 2'(grant - 3'd1);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - saturating load/enable down-counter with expire flag
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/junction_route_controller.sv
// rtl/junction_route_controller.sv - sets junction points for a granted train and tracks it through
module junction_route_controller
    import route_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 64,
    parameter int ENTRY_TIMEOUT = 256,
    parameter int CLEAR_HOLD    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] grant,
    input  logic       switch_locked,
    input  logic       occupied,
    input  logic       fault_clear,
    output logic [1:0] switch_pos,
    output logic [3:0] signal_green,
    output logic       train_done,
    output logic       fault
);

    localparam int MAX_A = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (ENTRY_TIMEOUT > CLEAR_HOLD) ? ENTRY_TIMEOUT : CLEAR_HOLD;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    // The timer expires on the cycle after it reaches zero, so each load is one short.
    // The first clear cycle is consumed by the OCCUPIED -> CLEARING step, hence minus two.
    localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD  = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'((CLEAR_HOLD > 1) ? CLEAR_HOLD - 2 : 0);

    route_state_t     state;
    route_state_t     state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expired;

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:      if (grant_valid(grant)) state_d = ST_SET_ROUTE;
            ST_SET_ROUTE: if (switch_locked) state_d = ST_SETTLE;
                          else if (tmr_expired) state_d = ST_FAULT;
            ST_SETTLE:    if (!switch_locked) state_d = ST_SET_ROUTE;
                          else if (tmr_expired) state_d = ST_PROCEED;
            // Entry wins over both lock loss and timeout once the train is on the circuit.
            ST_PROCEED:   if (occupied) state_d = ST_OCCUPIED;
                          else if (!switch_locked || tmr_expired) state_d = ST_FAULT;
            ST_OCCUPIED:  if (!occupied) state_d = (CLEAR_HOLD > 1) ? ST_CLEARING : ST_DONE;
            ST_CLEARING:  if (occupied) state_d = ST_OCCUPIED;
                          else if (tmr_expired) state_d = ST_DONE;
            ST_DONE:      state_d = ST_HOLDOFF;
            ST_HOLDOFF:   state_d = ST_IDLE;
            ST_FAULT:     if (fault_clear) state_d = ST_DONE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_load = (state_d != state);
        case (state_d)
            ST_SET_ROUTE: tmr_value = LOCK_LOAD;
            ST_SETTLE:    tmr_value = SETTLE_LOAD;
            ST_PROCEED:   tmr_value = ENTRY_LOAD;
            ST_CLEARING:  tmr_value = CLEAR_LOAD;
            default:      tmr_value = '0;
        endcase
    end

    hold_timer #(
        .WIDTH(CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .enable     (!tmr_load),
        .expired    (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            switch_pos   <= '0;
            signal_green <= '0;
            train_done   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && state_d == ST_SET_ROUTE) begin
                switch_pos <= grant_to_route(grant);
            end
            signal_green <= (state_d == ST_PROCEED) ? (4'b0001 << switch_pos) : 4'b0000;
            train_done   <= (state_d == ST_DONE);
            fault        <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_junction_route_controller.sv
// tb/tb_junction_route_controller.sv - randomized timeline checks for junction_route_controller
module tb_junction_route_controller;

    localparam int SETTLE   = 4;
    localparam int HOLD     = 3;
    localparam int LOCK_TO  = 16;
    localparam int ENTRY_TO = 16;
    localparam int N        = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] grant = 3'd0;
    logic       switch_locked = 1'b0;
    logic       occupied = 1'b0;
    logic       fault_clear = 1'b0;
    logic [1:0] switch_pos;
    logic [3:0] signal_green;
    logic       train_done;
    logic       fault;

    int n_cmp = 0;
    int n_bad = 0;
    int last_pos = 0;

    logic [2:0] gr[N];
    logic       lk[N];
    logic       oc[N];
    logic       fc[N];
    logic [3:0] e_green[N];
    logic       e_done[N];
    logic       e_fault[N];

    junction_route_controller #(
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (LOCK_TO),
        .ENTRY_TIMEOUT (ENTRY_TO),
        .CLEAR_HOLD    (HOLD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .grant         (grant),
        .switch_locked (switch_locked),
        .occupied      (occupied),
        .fault_clear   (fault_clear),
        .switch_pos    (switch_pos),
        .signal_green  (signal_green),
        .train_done    (train_done),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int pos, input int green, input int done, input int flt);
        check($sformatf("%s switch_pos", tag), int'(switch_pos), pos);
        check($sformatf("%s signal_green", tag), int'(signal_green), green);
        check($sformatf("%s train_done", tag), int'(train_done), done);
        check($sformatf("%s fault", tag), int'(fault), flt);
    endtask

    task automatic idle_invalid(input int cycles);
        int t;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            t = $urandom_range(0, 3);
            grant         = (t == 0) ? 3'd0 : 3'(4 + t);
            switch_locked = 1'($urandom_range(0, 1));
            occupied      = 1'($urandom_range(0, 1));
            fault_clear   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_all($sformatf("idle g%0d", grant), last_pos, 0, 0, 0);
        end
        @(negedge clk);
        grant = 3'd0;
    endtask

    // mode: 0 nominal, 1 lock never, 2 entry timeout, 3 lock lost in proceed, 4 settle drop
    task automatic run_route(input int mode, input int g, input bit abort);
        int m, t, n, g_at, f_at, c_at, d_at, p_at, q_at, len, abort_k;
        logic [3:0] one;
        one  = 4'(1 << (g - 1));
        g_at = 0;
        f_at = -1;
        for (int k = 0; k < N; k++) begin
            gr[k] = 3'd0; lk[k] = 1'b0; oc[k] = 1'b0; fc[k] = 1'b0;
            e_green[k] = 4'd0; e_done[k] = 1'b0; e_fault[k] = 1'b0;
        end
        if (mode == 1) begin
            f_at = LOCK_TO;
        end else begin
            m = 1 + $urandom_range(0, 4);
            for (int k = m; k < N; k++) lk[k] = 1'b1;
            if (mode == 4) begin
                t = m + $urandom_range(1, SETTLE - 1);
                n = $urandom_range(1, 3);
                for (int k = t; k < t + n; k++) lk[k] = 1'b0;
                m = t + n;
            end
            g_at = m + SETTLE;
            if (mode == 2) f_at = g_at + ENTRY_TO;
            if (mode == 3) begin
                f_at = g_at + $urandom_range(1, 10);
                for (int k = f_at; k < N; k++) lk[k] = 1'b0;
            end
        end
        if (f_at >= 0) begin
            c_at = f_at + $urandom_range(1, 5);
            for (int k = 0; k < f_at; k++) fc[k] = 1'($urandom_range(0, 1));
            fc[c_at] = 1'b1;
            for (int k = f_at; k < c_at; k++) e_fault[k] = 1'b1;
            if (mode != 1) for (int k = g_at; k < f_at; k++) e_green[k] = one;
            d_at = c_at;
        end else begin
            p_at = g_at + $urandom_range(1, ENTRY_TO);
            for (int k = g_at; k < p_at; k++) e_green[k] = one;
            q_at = p_at + $urandom_range(0, 4);
            for (int k = p_at; k <= q_at; k++) oc[k] = 1'b1;
            n = $urandom_range(0, 2);
            for (int b = 0; b < n; b++) begin
                t = q_at + $urandom_range(2, HOLD);
                q_at = t + $urandom_range(0, 1);
                for (int k = t; k <= q_at; k++) oc[k] = 1'b1;
            end
            d_at = q_at + HOLD;
        end
        gr[0] = 3'(g);
        for (int k = 1; k <= d_at; k++) gr[k] = 3'($urandom_range(0, 7));
        gr[d_at + 1] = 3'($urandom_range(1, 4));
        e_done[d_at] = 1'b1;
        len = d_at + 3;
        abort_k = !abort ? -1 : (f_at >= 0) ? f_at : g_at;

        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            grant = gr[k]; switch_locked = lk[k]; occupied = oc[k]; fault_clear = fc[k];
            @(posedge clk);
            #1;
            check_all($sformatf("m%0d g%0d k%0d", mode, g, k), g - 1, int'(e_green[k]),
                      int'(e_done[k]), int'(e_fault[k]));
            if (k == abort_k) begin
                #2 reset_n = 1'b0;
                #1 check_all("reset async", 0, 0, 0, 0);
                for (int r = 0; r < 3; r++) begin
                    @(posedge clk);
                    #1 check_all("reset held", 0, 0, 0, 0);
                end
                @(negedge clk);
                grant = 3'd0; switch_locked = 1'b0; occupied = 1'b0; fault_clear = 1'b0;
                reset_n = 1'b1;
                @(posedge clk);
                #1 check_all("reset released", 0, 0, 0, 0);
                last_pos = 0;
                return;
            end
        end
        last_pos = g - 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_invalid(3);
        run_route(0, 3, 1'b0);
        idle_invalid(2);
        run_route(4, 3, 1'b0);
        run_route(2, 1, 1'b0);
        run_route(1, 4, 1'b0);
        run_route(3, 2, 1'b0);
        run_route(0, 2, 1'b1);
        idle_invalid(2);
        run_route(2, 4, 1'b1);
        for (int i = 0; i < 40; i++) begin
            run_route($urandom_range(0, 4), $urandom_range(1, 4), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_invalid($urandom_range(1, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/junction_route_controller.md
# junction_route_controller

Downstream stage of the train traffic arbiter. Consumes the arbiter's 3-bit `grant` code and sets the junction points for the granted train. It waits for points lock and settle, then shows a proceed aspect on that train's signal and tracks the train through the junction on the track-circuit input. When the junction is clear it returns the single-cycle `train_done` pulse the arbiter uses to release the grant.

## Interface
- `SETTLE_CYCLES`, default 8: cycles the points must stay locked before the signal clears.
- `LOCK_TIMEOUT`, default 64: maximum cycles to wait for `switch_locked` before faulting.
- `ENTRY_TIMEOUT`, default 256: maximum cycles in proceed without the train entering before faulting.
- `CLEAR_HOLD`, default 4: consecutive unoccupied cycles required to declare the junction clear.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `grant` in 3: 0 = none, 1..4 = train 1..4, 5..7 = invalid.
- `switch_locked` in 1: points detection; high when the points are locked in the commanded position. Synchronous to `clk`.
- `occupied` in 1: junction track circuit; high while a train is in the junction. Synchronous to `clk`.
- `fault_clear` in 1: operator acknowledge; honoured only in FAULT.
- `switch_pos` out 2: commanded route, equal to `grant`−1.
- `signal_green` out 4: one-hot proceed aspect; bit i belongs to train i+1.
- `train_done` out 1: one-cycle pulse that releases the arbiter grant.
- `fault` out 1: high while in FAULT.

## Operation
- States: IDLE, SET_ROUTE, SETTLE, PROCEED, OCCUPIED, CLEARING, DONE, HOLDOFF, FAULT.
- IDLE → SET_ROUTE when `grant` is in 1..4. The controller latches `route` = `grant`−1 and drives `switch_pos` = `route`. `grant` values 0 and 5..7 are ignored.
- The latched route is fixed until DONE. Changes to `grant` outside IDLE are ignored.
- SET_ROUTE → SETTLE when `switch_locked`=1.
- SET_ROUTE → FAULT after `LOCK_TIMEOUT` cycles without lock.
- SETTLE: counts `SETTLE_CYCLES` cycles with `switch_locked`=1.
  - Lock lost during SETTLE → SET_ROUTE; the lock timeout restarts.
  - Count complete → PROCEED.
- PROCEED: `signal_green[route]`=1.
  - `occupied`=1 → OCCUPIED.
  - `ENTRY_TIMEOUT` expiry → FAULT.
  - `switch_locked`=0 → FAULT immediately.
- OCCUPIED: `signal_green`=0, so the signal returns to danger behind the train. `occupied`=0 → CLEARING.
- CLEARING: counts consecutive cycles with `occupied`=0.
  - `occupied`=1 → OCCUPIED; the count resets.
  - `CLEAR_HOLD` reached → DONE.
- DONE: `train_done`=1 for exactly one cycle, then HOLDOFF.
- HOLDOFF: one cycle in which `grant` is ignored, so the arbiter's stale grant is never re-latched. Then IDLE.
- FAULT: `fault`=1, `signal_green`=0, `switch_pos` held. `fault_clear`=1 → DONE, which releases the arbiter grant.
- At most one bit of `signal_green` is ever set. It is set only in PROCEED.
- Counters are sized $clog2 of the largest parameter plus 1 and saturate. There is no wrap-around.

## Timing
- All outputs are registered.
- Reset values: `switch_pos`=0, `signal_green`=0, `train_done`=0, `fault`=0, state IDLE, counters 0.
- `reset_n` low in any state forces the reset values immediately, including mid-route and mid-FAULT. No `train_done` is emitted on reset.
- Grant pipeline: `grant` valid in IDLE at edge N → `switch_pos` valid after N.
- Settle: first `switch_locked`=1 sampled at edge M → `signal_green` set after edge M+`SETTLE_CYCLES`.
- Entry: `occupied`=1 sampled at edge P → `signal_green` clear after P.
- Clearing: last `occupied`=1 at edge Q, then low → `train_done` high for the cycle after edge Q+`CLEAR_HOLD`.
- Earliest re-grant after `train_done`: 2 cycles after the pulse (HOLDOFF, then IDLE).
- Simultaneous events:
  - In PROCEED, entry takes priority over timeout.
  - In CLEARING, `occupied` taking priority means re-occupation in the final counted cycle returns to OCCUPIED.

## Structure
- Shared package `route_pkg` holds:
  - the state enum;
  - `GRANT_NONE`=0 and `NUM_TRAINS`=4;
  - the `grant_valid()` and `grant_to_route()` functions.
- One sub-module, `hold_timer`, implements a load/enable/expire down-counter of parameterised width. The controller instantiates it once and reloads it on every state entry (settle, lock timeout, entry timeout, clear hold).

## Test plan
Parameters for all scenarios: `SETTLE_CYCLES`=4, `CLEAR_HOLD`=3, `LOCK_TIMEOUT`=16, `ENTRY_TIMEOUT`=16.

- **Nominal route:** `grant`=3, `switch_locked` high 2 cycles later, `occupied` pulsed 5 cycles. Required:
  - `switch_pos`=2;
  - `signal_green`=4'b0100 exactly 4 cycles after lock, cleared on entry;
  - one `train_done` pulse 3 cycles after `occupied` falls.
- **Grant change mid-route:** `grant` changes 3→1 during SETTLE. Required: `switch_pos` stays 2 and only bit 2 goes green.
- **Entry timeout:** no `occupied` after green. Required:
  - `fault`=1 and `signal_green`=0 after 16 cycles;
  - `fault_clear` → one `train_done` pulse, `fault`=0;
  - `grant` ignored for one cycle after the pulse.
- **Lock lost:** `switch_locked` lost at settle cycle 2, then relocks. Required: green exactly 4 cycles after relock. Also: lock never arriving → `fault` after 16 cycles.
- **Occupancy bounce:** `occupied` glitches high 1 cycle inside CLEARING. Required: `train_done` 3 cycles after the final fall, not earlier.
- **Reset and invalid grants:** `reset_n` low while green. Required: all outputs 0 asynchronously, no `train_done`. `grant`=6 in IDLE → state unchanged.
